// File: rtl/acct_pkg.sv
// Shared definitions for the access-control shadow/commit block:
// register map offsets, commit FSM states and STATUS field layout.
package acct_pkg;

  // Local copy of the SoC peripheral count so the block elaborates standalone.
  localparam int NB_PERIPH_DFLT = 9;

  // CTRL and STATUS sit directly above the shadow words.
  localparam int CTRL_OFS   = 0;
  localparam int STATUS_OFS = 1;

  localparam int ST_BUSY_BIT = 0;
  localparam int ST_VIOL_LSB = 8;
  localparam int ST_VIOL_W   = 8;
  localparam int ST_CCNT_LSB = 16;
  localparam int ST_CCNT_W   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_COPY = 1'b1
  } fsm_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/acct_commit_fsm.sv
// Commit sequencer: walks one slave per cycle from shadow to active,
// then bumps the wrapping commit counter.
module acct_commit_fsm import acct_pkg::*; #(
  parameter int NB_SLAVE = 3,
  parameter int SW       = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start,
  output logic                 busy,
  output logic                 copy_en,
  output logic [SW-1:0]        copy_idx,
  output logic [ST_CCNT_W-1:0] commit_cnt
);

  fsm_state_e    state_q, state_d;
  logic [SW-1:0] s_q;
  logic          last;

  assign last = (s_q == SW'(NB_SLAVE - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      commit_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_COPY) begin
        s_q <= last ? '0 : s_q + SW'(1);
        if (last) commit_cnt <= commit_cnt + ST_CCNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_COPY;
      ST_COPY: if (last)  state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == ST_COPY);
    copy_en  = busy;
    copy_idx = s_q;
  end

endmodule

// File: rtl/acct_shadow_ctrl.sv
// Shadowed access-control registers with staged, per-slave commit.
// Optional ACCT_VIOL_CNT_EN adds a saturating locked-write violation counter.
module acct_shadow_ctrl import acct_pkg::*; #(
  parameter int NB_SLAVE  = 3,
  parameter int NB_PERIPH = NB_PERIPH_DFLT
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [2*NB_SLAVE-1:0]                reglk_ctrl_i,
  input  logic                                 reg_valid_i,
  input  logic                                 reg_write_i,
  input  logic [11:0]                          reg_addr_i,
  input  logic [31:0]                          reg_wdata_i,
  output logic [31:0]                          reg_rdata_o,
  output logic                                 reg_ready_o,
  output logic                                 reg_error_o,
  output logic [NB_SLAVE-1:0][4*NB_PERIPH-1:0] acc_ctrl_o
);

  localparam int WPS = ceil_div(4 * NB_PERIPH, 32);
  localparam int NW  = NB_SLAVE * WPS;
  localparam int SW  = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;

  logic [NW-1:0][31:0]    shadow_q, active_q;
  logic [31:0]            idx;
  logic                   in_shadow, is_ctrl, is_status, out_range, wlk, rlk;
  logic                   acc_ok, shadow_we, commit_req;
  logic                   busy, copy_en;
  logic [SW-1:0]          copy_idx;
  logic [ST_CCNT_W-1:0]   commit_cnt;
  logic [ST_VIOL_W-1:0]   viol_cnt;
  logic                   addr_lsb_unused;

  assign addr_lsb_unused = ^reg_addr_i[1:0];
  assign idx       = {22'd0, reg_addr_i[11:2]};
  assign in_shadow = (idx < NW);
  assign is_ctrl   = (idx == NW + CTRL_OFS);
  assign is_status = (idx == NW + STATUS_OFS);
  assign out_range = (idx > NW + STATUS_OFS);

  always_comb begin
    wlk = 1'b0;
    rlk = 1'b0;
    for (int s = 0; s < NB_SLAVE; s++)
      if (idx >= s * WPS && idx < (s + 1) * WPS) begin
        wlk = reglk_ctrl_i[2*s];
        rlk = reglk_ctrl_i[2*s+1];
      end
  end

  // Bus side effects only while idle and out of reset; a busy cycle stalls.
  assign acc_ok     = reg_valid_i & ~busy & ~rst_i;
  assign shadow_we  = acc_ok & reg_write_i & in_shadow & ~wlk;
  assign commit_req = acc_ok & reg_write_i & is_ctrl & reg_wdata_i[0];

  acct_commit_fsm #(.NB_SLAVE(NB_SLAVE), .SW(SW)) u_fsm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start      (commit_req),
    .busy       (busy),
    .copy_en    (copy_en),
    .copy_idx   (copy_idx),
    .commit_cnt (commit_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '1;
      active_q <= '1;
    end else begin
      for (int w = 0; w < NW; w++)
        if (shadow_we && idx == w) shadow_q[w] <= reg_wdata_i;
      // Write lock is sampled in the copy cycle itself, not at commit request.
      for (int s = 0; s < NB_SLAVE; s++)
        if (copy_en && copy_idx == SW'(s) && !reglk_ctrl_i[2*s])
          for (int k = 0; k < WPS; k++)
            active_q[s*WPS+k] <= shadow_q[s*WPS+k];
    end
  end

`ifdef ACCT_VIOL_CNT_EN
  logic viol_hit;
  assign viol_hit = acc_ok & reg_write_i & in_shadow & wlk;
  always_ff @(posedge clk_i) begin
    if (rst_i) viol_cnt <= '0;
    else if (viol_hit && viol_cnt != '1) viol_cnt <= viol_cnt + ST_VIOL_W'(1);
  end
`else
  assign viol_cnt = '0;
`endif

  always_comb begin
    reg_rdata_o = '0;
    if (!rst_i) begin
      if (in_shadow && !rlk) begin
        for (int w = 0; w < NW; w++)
          if (idx == w) reg_rdata_o = shadow_q[w];
      end else if (is_status) begin
        reg_rdata_o[ST_BUSY_BIT]               = busy;
        reg_rdata_o[ST_VIOL_LSB +: ST_VIOL_W]  = viol_cnt;
        reg_rdata_o[ST_CCNT_LSB +: ST_CCNT_W]  = commit_cnt;
      end
    end
  end

  assign reg_ready_o = rst_i | ~busy;
  assign reg_error_o = acc_ok & ((reg_write_i & ((in_shadow & wlk) | is_status)) | out_range);

  for (genvar s = 0; s < NB_SLAVE; s++) begin : g_acc
    logic [WPS*32-1:0] slv_bits;
    assign slv_bits      = active_q[s*WPS +: WPS];
    assign acc_ctrl_o[s] = slv_bits[4*NB_PERIPH-1:0];
    if (WPS * 32 > 4 * NB_PERIPH) begin : g_pad
      logic pad_unused;
      assign pad_unused = ^slv_bits[WPS*32-1:4*NB_PERIPH];
    end
  end

endmodule

// File: tb/tb_acct_shadow_ctrl.sv
// Directed bench for acct_shadow_ctrl: reset, staging, locks, commit, stall, abort, saturation.
module tb_acct_shadow_ctrl;

  localparam int NB_SLAVE  = 3;
  localparam int NB_PERIPH = 9;
  localparam logic [35:0] ONES = '1;

  logic                                 clk = 1'b0;
  logic                                 rst;
  logic [2*NB_SLAVE-1:0]                reglk;
  logic                                 valid, write;
  logic [11:0]                          addr;
  logic [31:0]                          wdata, rdata;
  logic                                 ready, error;
  logic [NB_SLAVE-1:0][4*NB_PERIPH-1:0] acc;

  int          n_chk = 0, n_err = 0;
  logic [7:0]  viol_exp1, viol_sat;
  logic        r_rdy, r_err;
  logic [31:0] r_data;

  always #5 clk = ~clk;

  acct_shadow_ctrl #(.NB_SLAVE(NB_SLAVE), .NB_PERIPH(NB_PERIPH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .reglk_ctrl_i(reglk),
    .reg_valid_i (valid),
    .reg_write_i (write),
    .reg_addr_i  (addr),
    .reg_wdata_i (wdata),
    .reg_rdata_o (rdata),
    .reg_ready_o (ready),
    .reg_error_o (error),
    .acc_ctrl_o  (acc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle bus access; response sampled mid-cycle before the accepting edge.
  task automatic bus(input logic w, input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1; write = w; addr = a; wdata = d;
    #1;
    r_rdy = ready; r_err = error; r_data = rdata;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  initial begin
`ifdef ACCT_VIOL_CNT_EN
    viol_exp1 = 8'd1; viol_sat = 8'd255;
`else
    viol_exp1 = 8'd0; viol_sat = 8'd0;
`endif
    rst = 1'b1; reglk = '0; valid = 1'b0; write = 1'b0; addr = '0; wdata = '0;

    // In reset: ready=1, error=0, rdata=0 for index 0
    @(negedge clk); valid = 1'b1; write = 1'b0; addr = 12'h000; #1;
    chk("rst_ready", ready, 1);
    chk("rst_error", error, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1 valid = 1'b0; rst = 1'b0;

    chk("rst_acc0", acc[0], ONES);
    chk("rst_acc1", acc[1], ONES);
    chk("rst_acc2", acc[2], ONES);
    bus(0, 12'h000, 0);
    chk("rd0_data", r_data, 32'hFFFF_FFFF);
    chk("rd0_ready", r_rdy, 1);
    chk("rd0_error", r_err, 0);

    // Staged write does not reach acc_ctrl_o
    bus(1, 12'h000, 32'h0000_00F0);
    chk("wr0_error", r_err, 0);
    chk("staged_acc0", acc[0], ONES);
    bus(0, 12'h000, 0);
    chk("shadow0", r_data, 32'h0000_00F0);

    // Commit at t, read stalls during COPY
    @(negedge clk); valid = 1'b1; write = 1'b1; addr = 12'h018; wdata = 32'h1; #1;
    chk("cmt_ready", ready, 1);
    chk("cmt_error", error, 0);
    @(posedge clk); #1 write = 1'b0; addr = 12'h000;
    chk("copy_t1_acc0", acc[0], ONES);
    @(negedge clk); chk("stall1", ready, 0);
    @(posedge clk); #1;
    chk("copy_t2_acc0", acc[0], 36'hF_0000_00F0);
    @(negedge clk); chk("stall2", ready, 0);
    @(posedge clk); @(negedge clk); chk("stall3", ready, 0);
    @(posedge clk); @(negedge clk);
    chk("stall_done", ready, 1);
    chk("stall_data", rdata, 32'h0000_00F0);
    @(posedge clk); #1 valid = 1'b0;
    bus(0, 12'h01C, 0);
    chk("status_c1", r_data, 32'h0001_0000);

    // Write lock on slave 1
    reglk = 6'b000100;
    bus(1, 12'h008, 32'h1234);
    chk("wlk_ready", r_rdy, 1);
    chk("wlk_error", r_err, 1);
    bus(0, 12'h008, 0);
    chk("wlk_shadow", r_data, 32'hFFFF_FFFF);
    bus(0, 12'h01C, 0);
    chk("wlk_status", r_data, {16'd1, viol_exp1, 8'h00});

    // Read lock on slave 0
    reglk = 6'b000010;
    bus(0, 12'h000, 0);
    chk("rlk_data", r_data, 0);
    chk("rlk_error", r_err, 0);
    reglk = '0;

    // Slave 0 write-locked during commit
    bus(1, 12'h000, 32'hAA);
    bus(1, 12'h008, 32'h55);
    bus(1, 12'h010, 32'h77);
    reglk = 6'b000001;
    bus(1, 12'h018, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("lkc_acc0", acc[0], 36'hF_0000_00F0);
    chk("lkc_acc1", acc[1], 36'hF_0000_0055);
    chk("lkc_acc2", acc[2], 36'hF_0000_0077);
    reglk = '0;
    bus(0, 12'h01C, 0);
    chk("status_c2", r_data, {16'd2, viol_exp1, 8'h00});

    // Reset mid-COPY aborts
    bus(1, 12'h000, 32'h11);
    bus(1, 12'h008, 32'h22);
    bus(1, 12'h018, 32'h1);
    @(posedge clk); #1;
    chk("abort_partial", acc[0], 36'hF_0000_0011);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_acc0", acc[0], ONES);
    chk("abort_acc1", acc[1], ONES);
    chk("abort_acc2", acc[2], ONES);
    rst = 1'b0;
    bus(0, 12'h01C, 0);
    chk("abort_status", r_data, 0);
    bus(0, 12'h000, 0);
    chk("abort_shadow", r_data, 32'hFFFF_FFFF);

    // Violation counter saturation
    reglk = 6'b000001;
    repeat (300) bus(1, 12'h000, 32'h5A);
    chk("sat_error", r_err, 1);
    reglk = '0;
    bus(0, 12'h01C, 0);
    chk("sat_status", r_data, {16'd0, viol_sat, 8'h00});

    // Range, STATUS write, CTRL no-op
    bus(0, 12'h020, 0);
    chk("oor_data", r_data, 0);
    chk("oor_error", r_err, 1);
    bus(1, 12'h01C, 32'hFFFF);
    chk("stw_error", r_err, 1);
    bus(1, 12'h018, 32'h0);
    chk("ctrl0_error", r_err, 0);
    bus(0, 12'h018, 0);
    chk("ctrl_rd_ready", r_rdy, 1);
    chk("ctrl_rd_data", r_data, 0);
    bus(0, 12'h01C, 0);
    chk("final_status", r_data, {16'd0, viol_sat, 8'h00});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/acct_shadow_ctrl.md
ACCT_SHADOW_CTRL -- requirements
Module: acct_shadow_ctrl

Interface
REQ-001 SHALL have parameter NB_SLAVE, default 3: number of slave interfaces with access-control fields.
REQ-002 SHALL have parameter NB_PERIPH, default ariane_soc::NB_PERIPHERALS: peripherals per slave, 4 bits each.
REQ-003 SHALL derive localparam WPS = ceil(4*NB_PERIPH/32), the words per slave, and NW = NB_SLAVE*WPS.
REQ-004 SHALL have clk_i, input, 1: the single clock; all logic on posedge.
REQ-005 SHALL have rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have reglk_ctrl_i, input, 2*NB_SLAVE: bit 2s locks writes to slave s; bit 2s+1 locks reads of slave s.
REQ-007 SHALL have reg_valid_i, input, 1: a bus access is present.
REQ-008 SHALL have reg_write_i, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have reg_addr_i, input, 12: byte address; the word index is reg_addr_i[11:2].
REQ-010 SHALL have reg_wdata_i, input, 32: write data.
REQ-011 SHALL have reg_rdata_o, output, 32: read data, combinational.
REQ-012 SHALL have reg_ready_o, output, 1: the access completes this cycle.
REQ-013 SHALL have reg_error_o, output, 1: the access is rejected.
REQ-014 SHALL have acc_ctrl_o, output, NB_SLAVE x 4*NB_PERIPH: active access-control values; slave s takes the low 4*NB_PERIPH bits of {active[s*WPS+WPS-1] .. active[s*WPS]}.

Function
REQ-015 SHALL map word index i < NW to shadow word i, with read/write access.
REQ-016 SHALL map word index NW to CTRL: a write with bit0 = 1 requests a commit; reads return 0.
REQ-017 SHALL map word index NW+1 to STATUS, read-only:
- bit0 = busy;
- bits[15:8] = violation count;
- bits[31:16] = commit count, wrapping.
REQ-018 SHALL write a shadow word the cycle after an accepted write, unless that word's slave is write-locked.
REQ-019 SHALL, on a write to a write-locked slave, leave the shadow unchanged and assert reg_ready_o=1 and reg_error_o=1 in the same cycle.
REQ-020 SHALL, on a read of a read-locked slave, return rdata 0 with error=0.
REQ-021 SHALL, for an index above NW+1, return rdata 0, ignore writes, and assert error=1.
REQ-022 SHALL, for a write to STATUS, ignore the write and assert error=1.
REQ-023 SHALL implement the commit FSM as IDLE -> COPY -> IDLE:
- a CTRL bit0 write accepted in IDLE at cycle t moves the FSM to COPY at t+1;
- COPY uses slave counter s = 0..NB_SLAVE-1, one slave per cycle;
- in each COPY cycle, active words of slave s <= shadow words, unless slave s is write-locked in that cycle, in which case they are skipped;
- after s = NB_SLAVE-1 the FSM returns to IDLE and the commit count increments.
REQ-024 SHALL therefore make new acc_ctrl_o for slave s visible from cycle t+2+s; busy = (state == COPY).
REQ-025 SHALL, while busy, force reg_ready_o=0 for every access so the bus stalls; no state changes from the bus.
REQ-026 SHALL assert reg_ready_o=1 whenever the FSM is IDLE, valid or not.
REQ-027 SHALL treat a CTRL write with bit0 = 0 as a no-op with error=0.
REQ-028 SHALL never change acc_ctrl_o except in COPY.

Reset
REQ-029 SHALL, while rst_i is high at a clock edge, set all shadow and active words to 32'hFFFFFFFF, the FSM to IDLE, s to 0, and both counters to 0.
REQ-030 SHALL abort an in-progress COPY on reset; partially copied values are overwritten by reset values.
REQ-031 SHALL hold reg_ready_o=1, reg_error_o=0 and reg_rdata_o=0 for index 0 while in reset.

Configuration
REQ-032 SHALL, with ACCT_VIOL_CNT_EN defined, count every locked-write rejection (REQ-019) in an 8-bit counter that saturates at 255.
REQ-033 SHALL, without ACCT_VIOL_CNT_EN, omit the counter and return STATUS[15:8] = 0; all else is identical.

Structure
REQ-034 SHALL place the CTRL/STATUS index offsets, the FSM state enum, and the STATUS field positions in package acct_pkg.
REQ-035 SHALL contain one sub-module, acct_commit_fsm, holding the state, slave counter and commit count, with outputs busy, copy_en and copy_idx.

Verification
REQ-036 SHALL verify reset and readback: after reset, acc_ctrl_o is all ones; reading index 0 returns 32'hFFFFFFFF with ready=1 and error=0.
REQ-037 SHALL verify staged commit:
- write 32'h0000_00F0 to word 0 -> acc_ctrl_o[0] is unchanged;
- commit at t -> busy during t+1..t+NB_SLAVE;
- acc_ctrl_o[0] low word = 32'h0000_00F0 from t+2.
REQ-038 SHALL verify the write lock:
- with reglk_ctrl_i[2] = 1, write 32'h1234 to word WPS -> error=1 and shadow unchanged;
- STATUS[15:8] = 1 with ACCT_VIOL_CNT_EN, 0 without.
REQ-039 SHALL verify the lock during commit: set reglk_ctrl_i[0] = 1 while committing a modified shadow word 0 -> acc_ctrl_o[0] is not updated; slaves 1..NB_SLAVE-1 are updated.
REQ-040 SHALL verify stall and abort:
- a read issued during COPY sees ready=0 until the cycle after COPY ends, then returns data;
- rst_i asserted mid-COPY makes acc_ctrl_o all ones on the next cycle.
REQ-041 SHALL verify saturation and range: 300 locked writes -> STATUS[15:8] = 255; a read of index NW+2 -> rdata 0, error=1.
